cpu_run_sequencer: RTL and testbench

//  Synchronous controller that sequences the single-cycle CPU for the touch-display top.
//  On a touch-screen entry it halts the CPU, pulses CPU reset, loads IN_1/IN_2 into data memory

---
 rtl/cpu_run_sequencer_pkg.sv | 29 ++
 rtl/cpu_run_sequencer_if.sv | 42 ++++
 rtl/cpu_run_sequencer_snoop.sv | 28 ++
 rtl/cpu_run_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cpu_run_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_sequencer_pkg.sv
// Shared types and default addresses for the CPU run sequencer.
// Decides where IN/OUT words live in data memory and how long a run may last.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HALT = 3'd1,
      RSTL = 3'd2,
      WR1  = 3'd3,
      WR2  = 3'd4,
      RUN  = 3'd5,
      DONE = 3'd6
   } seq_state_t;

   localparam int unsigned DEF_RST_CYCLES = 4;
   localparam int unsigned DEF_RUN_MAX    = 1024;

   localparam logic [31:0] DEF_ADDR_IN1  = 32'h0000_0000;
   localparam logic [31:0] DEF_ADDR_IN2  = 32'h0000_0004;
   localparam logic [31:0] DEF_ADDR_OUT1 = 32'h0000_0020;
   localparam logic [31:0] DEF_ADDR_OUT2 = 32'h0000_0030;

   // OUT_1/OUT_2 are matched as whole words; byte lanes are irrelevant.
   function automatic logic word_match(input logic [29:0] word_addr,
                                       input logic [31:0] byte_addr);
      return word_addr == byte_addr[31:2];
   endfunction

endpackage

// File: rtl/cpu_run_sequencer_if.sv
// Bundle between the sequencer and its surroundings (LCD entry, CPU DM port, DataMem ctl port).
// master = sequencer side, slave = environment side.
interface cpu_run_sequencer_if;

   logic        input_valid;
   logic        input_sel;
   logic [31:0] input_value;

   logic        cpu_dm_cs;
   logic        cpu_dm_w;
   logic [31:0] cpu_dm_addr;
   logic [31:0] cpu_dm_wdata;

   logic        cpu_clk_en;
   logic        cpu_rstn;
   logic        dm_ctl_sel;
   logic        dm_ctl_w;
   logic [31:0] dm_ctl_addr;
   logic [31:0] dm_ctl_wdata;

   logic [31:0] in1;
   logic [31:0] in2;
   logic [31:0] out1;
   logic [31:0] out2;
   logic        busy;
   logic        timeout;

   modport master (
      input  input_valid, input_sel, input_value,
      input  cpu_dm_cs, cpu_dm_w, cpu_dm_addr, cpu_dm_wdata,
      output cpu_clk_en, cpu_rstn, dm_ctl_sel, dm_ctl_w, dm_ctl_addr, dm_ctl_wdata,
      output in1, in2, out1, out2, busy, timeout
   );

   modport slave (
      output input_valid, input_sel, input_value,
      output cpu_dm_cs, cpu_dm_w, cpu_dm_addr, cpu_dm_wdata,
      input  cpu_clk_en, cpu_rstn, dm_ctl_sel, dm_ctl_w, dm_ctl_addr, dm_ctl_wdata,
      input  in1, in2, out1, out2, busy, timeout
   );

endinterface

// File: rtl/cpu_run_sequencer_snoop.sv
// Watches the CPU data-memory port and flags committed stores to OUT_1 / OUT_2.
// Purely combinational; the sequencer decides what to do with the strobes.
module seq_store_snoop
   import cpu_seq_pkg::*;
#(
   parameter logic [31:0] ADDR_OUT1 = DEF_ADDR_OUT1,
   parameter logic [31:0] ADDR_OUT2 = DEF_ADDR_OUT2
) (
   input  logic        cs,
   input  logic        w,
   input  logic        en,
   input  logic [31:0] addr,
   output logic        cap_out1,
   output logic        cap_out2
);

   logic store;
   logic unused_lsb;

   assign unused_lsb = ^addr[1:0];

   always_comb begin
      store    = cs & w & en;
      cap_out1 = store & word_match(addr[31:2], ADDR_OUT1);
      cap_out2 = store & word_match(addr[31:2], ADDR_OUT2);
   end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Halts, resets, preloads and runs the single-cycle CPU for each touch-screen entry.
//   state | meaning
//   IDLE  | nothing running, waiting for first entry
//   HALT  | CPU frozen one cycle, timeout flag cleared
//   RSTL  | cpu_rstn held low for RST_CYCLES cycles
//   WR1   | sequencer owns DataMem, writes in1 to ADDR_IN1
//   WR2   | sequencer owns DataMem, writes in2 to ADDR_IN2
//   RUN   | CPU clock enabled, stores snooped, run counter ticking
//   DONE  | run finished (OUT_2 store or timeout), results held
module cpu_run_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
   parameter int unsigned RUN_MAX    = DEF_RUN_MAX,
   parameter logic [31:0] ADDR_IN1   = DEF_ADDR_IN1,
   parameter logic [31:0] ADDR_IN2   = DEF_ADDR_IN2,
   parameter logic [31:0] ADDR_OUT1  = DEF_ADDR_OUT1,
   parameter logic [31:0] ADDR_OUT2  = DEF_ADDR_OUT2
) (
   input  logic                  clk,
   input  logic                  resetn,
   cpu_run_sequencer_if.master   bus
);

   localparam int unsigned RUN_W = $clog2(RUN_MAX) + 1;
   localparam int unsigned RST_W = $clog2(RST_CYCLES) + 1;

   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_MAX - 1);
   localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

   seq_state_t state, state_nxt;

   logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
   logic [RUN_W-1:0] run_cnt, run_cnt_nxt;

   logic [31:0] in1_q, in1_nxt;
   logic [31:0] in2_q, in2_nxt;
   logic [31:0] out1_q, out1_nxt;
   logic [31:0] out2_q, out2_nxt;
   logic        timeout_q, timeout_nxt;

   logic        clk_en_q, clk_en_nxt;
   logic        rstn_q, rstn_nxt;
   logic        sel_q, sel_nxt;
   logic        w_q, w_nxt;
   logic [31:0] addr_q, addr_nxt;
   logic [31:0] wdata_q, wdata_nxt;
   logic        busy_q, busy_nxt;

   logic snoop_en;
   logic cap_out1;
   logic cap_out2;

   assign snoop_en = clk_en_q & (state == RUN);

   seq_store_snoop #(
      .ADDR_OUT1 (ADDR_OUT1),
      .ADDR_OUT2 (ADDR_OUT2)
   ) u_snoop (
      .cs       (bus.cpu_dm_cs),
      .w        (bus.cpu_dm_w),
      .en       (snoop_en),
      .addr     (bus.cpu_dm_addr),
      .cap_out1 (cap_out1),
      .cap_out2 (cap_out2)
   );

   always_comb begin
      state_nxt   = state;
      rst_cnt_nxt = rst_cnt;
      run_cnt_nxt = run_cnt;
      in1_nxt     = in1_q;
      in2_nxt     = in2_q;
      out1_nxt    = out1_q;
      out2_nxt    = out2_q;
      timeout_nxt = timeout_q;

      // Entries are latched in every state; only IDLE/DONE/RUN react with a restart.
      if (bus.input_valid) begin
         if (bus.input_sel) in2_nxt = bus.input_value;
         else               in1_nxt = bus.input_value;
      end

      if (cap_out1) out1_nxt = bus.cpu_dm_wdata;
      if (cap_out2) out2_nxt = bus.cpu_dm_wdata;

      case (state)
         IDLE, DONE: begin
            if (bus.input_valid) state_nxt = HALT;
         end
         HALT: begin
            state_nxt   = RSTL;
            rst_cnt_nxt = RST_LOAD;
            timeout_nxt = 1'b0;
         end
         RSTL: begin
            if (rst_cnt == '0) state_nxt = WR1;
            else               rst_cnt_nxt = rst_cnt - 1'b1;
         end
         WR1: state_nxt = WR2;
         WR2: begin
            state_nxt   = RUN;
            run_cnt_nxt = '0;
         end
         RUN: begin
            // A new entry aborts the run; an OUT_2 store beats a same-cycle timeout.
            if (bus.input_valid) begin
               state_nxt = HALT;
            end else if (cap_out2) begin
               state_nxt = DONE;
            end else if (run_cnt == RUN_LAST) begin
               state_nxt   = DONE;
               timeout_nxt = 1'b1;
            end else begin
               run_cnt_nxt = run_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered alongside it.
      clk_en_nxt = (state_nxt == RUN);
      rstn_nxt   = (state_nxt != RSTL);
      sel_nxt    = (state_nxt == WR1) || (state_nxt == WR2);
      w_nxt      = sel_nxt;
      busy_nxt   = (state_nxt != IDLE) && (state_nxt != DONE);
      addr_nxt   = '0;
      wdata_nxt  = '0;
      if (state_nxt == WR1) begin
         addr_nxt  = ADDR_IN1;
         wdata_nxt = in1_nxt;
      end else if (state_nxt == WR2) begin
         addr_nxt  = ADDR_IN2;
         wdata_nxt = in2_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         rst_cnt   <= '0;
         run_cnt   <= '0;
         in1_q     <= '0;
         in2_q     <= '0;
         out1_q    <= '0;
         out2_q    <= '0;
         timeout_q <= 1'b0;
         clk_en_q  <= 1'b0;
         rstn_q    <= 1'b1;
         sel_q     <= 1'b0;
         w_q       <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         rst_cnt   <= rst_cnt_nxt;
         run_cnt   <= run_cnt_nxt;
         in1_q     <= in1_nxt;
         in2_q     <= in2_nxt;
         out1_q    <= out1_nxt;
         out2_q    <= out2_nxt;
         timeout_q <= timeout_nxt;
         clk_en_q  <= clk_en_nxt;
         rstn_q    <= rstn_nxt;
         sel_q     <= sel_nxt;
         w_q       <= w_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         busy_q    <= busy_nxt;
      end
   end

   assign bus.cpu_clk_en   = clk_en_q;
   assign bus.cpu_rstn     = rstn_q;
   assign bus.dm_ctl_sel   = sel_q;
   assign bus.dm_ctl_w     = w_q;
   assign bus.dm_ctl_addr  = addr_q;
   assign bus.dm_ctl_wdata = wdata_q;
   assign bus.in1          = in1_q;
   assign bus.in2          = in2_q;
   assign bus.out1         = out1_q;
   assign bus.out2         = out2_q;
   assign bus.busy         = busy_q;
   assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: dut_a (RUN_MAX=64) covers normal/abort/reset runs,
// dut_b (RUN_MAX=16) covers timeout and the last-cycle OUT_2 store.
module tb_cpu_run_sequencer;

   logic clk;
   logic resetn;

   int tests;
   int fails;
   int n_en;

   cpu_run_sequencer_if ifa ();
   cpu_run_sequencer_if ifb ();

   cpu_run_sequencer #(.RST_CYCLES(4), .RUN_MAX(64)) dut_a (
      .clk    (clk),
      .resetn (resetn),
      .bus    (ifa.master)
   );

   cpu_run_sequencer #(.RST_CYCLES(4), .RUN_MAX(16)) dut_b (
      .clk    (clk),
      .resetn (resetn),
      .bus    (ifb.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one unit's inputs; st=1 presents a CPU store (cs=w=1).
   task automatic drv(input int u, input logic v, input logic s, input logic [31:0] val,
                      input logic st, input logic [31:0] a, input logic [31:0] d);
      if (u == 0) begin
         ifa.input_valid = v;   ifa.input_sel = s;   ifa.input_value = val;
         ifa.cpu_dm_cs = st;    ifa.cpu_dm_w = st;   ifa.cpu_dm_addr = a;  ifa.cpu_dm_wdata = d;
      end else begin
         ifb.input_valid = v;   ifb.input_sel = s;   ifb.input_value = val;
         ifb.cpu_dm_cs = st;    ifb.cpu_dm_w = st;   ifb.cpu_dm_addr = a;  ifb.cpu_dm_wdata = d;
      end
   endtask

   task automatic quiet(input int u);
      drv(u, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      resetn = 1'b0;
      quiet(0);
      quiet(1);
      repeat (3) tick;

      chk("rst_clk_en",  {31'b0, ifa.cpu_clk_en}, 32'd0);
      chk("rst_cpu_rstn",{31'b0, ifa.cpu_rstn},   32'd1);
      chk("rst_dm_sel",  {31'b0, ifa.dm_ctl_sel}, 32'd0);
      chk("rst_dm_w",    {31'b0, ifa.dm_ctl_w},   32'd0);
      chk("rst_dm_addr", ifa.dm_ctl_addr,         32'd0);
      chk("rst_dm_wdata",ifa.dm_ctl_wdata,        32'd0);
      chk("rst_out2",    ifa.out2,                32'd0);
      chk("rst_busy",    {31'b0, ifa.busy},       32'd0);
      chk("rst_timeout", {31'b0, ifb.timeout},    32'd0);

      resetn = 1'b1;
      tick;

      // Entry IN_1=5: HALT, 4 reset cycles, preload, run.
      drv(0, 1'b1, 1'b0, 32'd5, 1'b0, 32'h0, 32'h0);
      tick;
      quiet(0);
      chk("halt_busy", {31'b0, ifa.busy},     32'd1);
      chk("halt_in1",  ifa.in1,               32'd5);
      chk("halt_rstn", {31'b0, ifa.cpu_rstn}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("rstl_rstn",   {31'b0, ifa.cpu_rstn},   32'd0);
         chk("rstl_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd0);
      end
      tick;
      chk("wr1_rstn",  {31'b0, ifa.cpu_rstn},   32'd1);
      chk("wr1_sel",   {31'b0, ifa.dm_ctl_sel}, 32'd1);
      chk("wr1_w",     {31'b0, ifa.dm_ctl_w},   32'd1);
      chk("wr1_addr",  ifa.dm_ctl_addr,         32'h00);
      chk("wr1_wdata", ifa.dm_ctl_wdata,        32'd5);
      tick;
      chk("wr2_w",     {31'b0, ifa.dm_ctl_w},   32'd1);
      chk("wr2_addr",  ifa.dm_ctl_addr,         32'h04);
      chk("wr2_wdata", ifa.dm_ctl_wdata,        32'd0);
      tick;
      chk("run_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd1);
      chk("run_sel",    {31'b0, ifa.dm_ctl_sel}, 32'd0);

      // Stores to OUT_1 then OUT_2 end the run.
      drv(0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'd7);
      tick;
      chk("st1_out1",   ifa.out1,                32'd7);
      chk("st1_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd1);
      drv(0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30, 32'd12);
      tick;
      quiet(0);
      chk("st2_out2",    ifa.out2,                32'd12);
      chk("st2_clk_en",  {31'b0, ifa.cpu_clk_en}, 32'd0);
      chk("st2_busy",    {31'b0, ifa.busy},       32'd0);
      chk("st2_timeout", {31'b0, ifa.timeout},    32'd0);

      drv(0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h99);
      tick;
      quiet(0);
      chk("done_store_ignored", ifa.out1, 32'd7);

      // New run with IN_1=11, aborted at run cycle 20 by IN_2=9.
      drv(0, 1'b1, 1'b0, 32'd11, 1'b0, 32'h0, 32'h0);
      tick;
      quiet(0);
      repeat (7) tick;
      chk("run2_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd1);
      repeat (20) tick;
      chk("run2_c20_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd1);
      drv(0, 1'b1, 1'b1, 32'd9, 1'b1, 32'h21, 32'd8);
      tick;
      quiet(0);
      chk("abort_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd0);
      chk("abort_busy",   {31'b0, ifa.busy},       32'd1);
      chk("abort_out1",   ifa.out1,                32'd8);
      chk("abort_in2",    ifa.in2,                 32'd9);
      tick;
      chk("abort_rstn", {31'b0, ifa.cpu_rstn}, 32'd0);
      repeat (3) tick;
      tick;
      chk("abort_wr1_addr",  ifa.dm_ctl_addr,  32'h00);
      chk("abort_wr1_wdata", ifa.dm_ctl_wdata, 32'd11);
      tick;
      chk("abort_wr2_addr",  ifa.dm_ctl_addr,  32'h04);
      chk("abort_wr2_wdata", ifa.dm_ctl_wdata, 32'd9);
      chk("out2_kept",       ifa.out2,         32'd12);
      tick;
      chk("run3_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd1);

      // Asynchronous reset in the middle of a run.
      repeat (3) tick;
      resetn = 1'b0;
      #1;
      chk("arst_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd0);
      chk("arst_rstn",   {31'b0, ifa.cpu_rstn},   32'd1);
      chk("arst_busy",   {31'b0, ifa.busy},       32'd0);
      chk("arst_out1",   ifa.out1,                32'd0);
      chk("arst_out2",   ifa.out2,                32'd0);
      chk("arst_in1",    ifa.in1,                 32'd0);
      chk("arst_in2",    ifa.in2,                 32'd0);
      tick;
      chk("arst_hold_clk_en", {31'b0, ifa.cpu_clk_en}, 32'd0);
      #2;
      resetn = 1'b1;
      tick;

      // Timeout on dut_b: exactly 16 enabled cycles.
      drv(1, 1'b1, 1'b0, 32'd1, 1'b0, 32'h0, 32'h0);
      tick;
      quiet(1);
      repeat (7) tick;
      n_en = 0;
      while (ifb.cpu_clk_en === 1'b1 && n_en < 40) begin
         n_en++;
         tick;
      end
      chk("to_cycles",  n_en,                32'd16);
      chk("to_timeout", {31'b0, ifb.timeout}, 32'd1);
      chk("to_busy",    {31'b0, ifb.busy},    32'd0);

      // Next entry clears timeout; an entry during RSTL reaches the preload.
      drv(1, 1'b1, 1'b1, 32'd2, 1'b0, 32'h0, 32'h0);
      tick;
      quiet(1);
      tick;
      chk("clr_timeout", {31'b0, ifb.timeout},  32'd0);
      chk("clr_rstn",    {31'b0, ifb.cpu_rstn}, 32'd0);
      drv(1, 1'b1, 1'b0, 32'h77, 1'b0, 32'h0, 32'h0);
      tick;
      quiet(1);
      chk("rstl_in1",  ifb.in1,               32'h77);
      chk("rstl_rstn", {31'b0, ifb.cpu_rstn}, 32'd0);
      repeat (2) tick;
      tick;
      chk("b_wr1_addr",  ifb.dm_ctl_addr,  32'h00);
      chk("b_wr1_wdata", ifb.dm_ctl_wdata, 32'h77);
      tick;
      chk("b_wr2_wdata", ifb.dm_ctl_wdata, 32'd2);
      tick;
      chk("b_run_clk_en", {31'b0, ifb.cpu_clk_en}, 32'd1);
      repeat (15) tick;
      chk("b_last_clk_en", {31'b0, ifb.cpu_clk_en}, 32'd1);
      drv(1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h32, 32'h55);
      tick;
      quiet(1);
      chk("tie_out2",    ifb.out2,                32'h55);
      chk("tie_timeout", {31'b0, ifb.timeout},    32'd0);
      chk("tie_clk_en",  {31'b0, ifb.cpu_clk_en}, 32'd0);
      chk("tie_busy",    {31'b0, ifb.busy},       32'd0);
      chk("tie_out1",    ifb.out1,                32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
